// File: rtl/logic_op_pipe.sv
// Bitwise logic unit with an optional accumulator operand, feeding a DEPTH-entry
// result FIFO with valid/ready handshakes and a tri-state result port.
module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             EN,
  output wire  [WIDTH-1:0] s,
  output logic             zero
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] head;
  logic             ready_q;
  logic             valid_q;
  logic             accept;
  logic             remove;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result    = a;
    operand_b = acc ? acc_q : b;
    case (op_e'(op))
      OP_AND:  result = a & operand_b;
      OP_OR:   result = a | operand_b;
      OP_XOR:  result = a ^ operand_b;
      OP_NAND: result = ~(a & operand_b);
      OP_NOR:  result = ~(a | operand_b);
      OP_XNOR: result = ~(a ^ operand_b);
      OP_NOTA: result = ~a;
      OP_PASS: result = a;
      default: result = a;
    endcase
  end

  // Reset masks both handshakes combinationally so nothing moves on the edge rst rises.
  assign in_ready = ready_q & ~rst;
  assign accept   = in_valid & in_ready;
  assign remove   = valid_q & out_ready & ~rst;

  always_comb begin
    count_next = count;
    case ({accept, remove})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: the data array holds no reset; valid_q/count alone decide whether an entry is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= result;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      acc_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
        acc_q  <= result;
      end
      if (remove) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      count   <= count_next;
      ready_q <= (count_next < FULL_CNT);
      valid_q <= (count_next != '0);
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = valid_q;
  assign zero      = valid_q & (head == '0);
  assign s         = (EN & valid_q) ? head : {WIDTH{1'bz}};

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe: directed scenarios plus random traffic,
// all compared against a queue-based reference model. Two instances observe s on pulled nets.
module tb_logic_op_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = '0;
  logic             acc = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             EN = 1'b0;

  logic             in_ready, out_valid, zero;
  logic             in_ready_lo, out_valid_lo, zero_lo;
  tri1 [WIDTH-1:0]  s_hi;
  tri0 [WIDTH-1:0]  s_lo;

  logic_op_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_hi (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .acc(acc),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .EN(EN), .s(s_hi), .zero(zero)
  );

  logic_op_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lo (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .acc(acc),
    .in_valid(in_valid), .in_ready(in_ready_lo), .out_valid(out_valid_lo),
    .out_ready(out_ready), .EN(EN), .s(s_lo), .zero(zero_lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered queue of pending results plus the accumulator value.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] model_acc = '0;
  bit               model_ready = 1'b0;

  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x & y);
      3'd4: r = ~(x | y);
      3'd5: r = ~(x ^ y);
      3'd6: r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // High-Z shows as all ones on the pulled-up net and all zeros on the pulled-down net.
  task automatic check_s(input string tag, input bit driven, input logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] exp_hi;
    logic [WIDTH-1:0] exp_lo;
    exp_hi = driven ? val : '1;
    exp_lo = driven ? val : '0;
    check({tag, "_hi"}, 64'(s_hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(s_lo), 64'(exp_lo));
  endtask

  // One clock cycle: check outputs against the model, then advance the model at the edge.
  task automatic tick();
    bit               v;
    bit               rdy;
    bit               take;
    bit               pop;
    logic [WIDTH-1:0] hd;
    logic [WIDTH-1:0] res;
    #1;
    v   = (model_q.size() > 0);
    hd  = v ? model_q[0] : '0;
    rdy = !rst && model_ready && (model_q.size() < DEPTH);
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("out_valid", 64'(out_valid), 64'(v));
    check("out_valid_lo", 64'(out_valid_lo), 64'(v));
    check("zero", 64'(zero), 64'(v && (hd == '0)));
    check_s("s", EN && v, hd);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_acc   = '0;
      model_ready = 1'b0;
    end else begin
      take = in_valid && rdy;
      pop  = v && out_ready;
      res  = ref_op(op, a, acc ? model_acc : b);
      if (pop) void'(model_q.pop_front());
      if (take) begin
        model_q.push_back(res);
        model_acc = res;
      end
      model_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  // Checks a specific hand-computed head value at the current cycle.
  task automatic expect_head(input string tag, input logic [WIDTH-1:0] val);
    #1;
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_zero"}, 64'(zero), 64'(val == '0));
    check_s(tag, 1'b1, val);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic [2:0] xop, input logic xacc);
    a = xa; b = xb; op = xop; acc = xacc; in_valid = 1'b1;
  endtask

  logic [WIDTH-1:0] sweep [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sweep[0] = 8'h0A; sweep[1] = 8'hCF; sweep[2] = 8'hC5; sweep[3] = 8'hF5;
    sweep[4] = 8'h30; sweep[5] = 8'h3A; sweep[6] = 8'h35; sweep[7] = 8'hCA;

    // Initial reset: DUT state is unknown before the first edge, so no checks yet.
    repeat (2) @(negedge clk);
    model_q.delete();
    model_acc   = '0;
    model_ready = 1'b0;
    tick();                       // rst still high: in_ready=0, out_valid=0, s=Z
    rst = 1'b0;
    EN  = 1'b1;
    tick();                       // first edge after deassert: in_ready becomes 1
    #1;
    check("ready_after_reset", 64'(in_ready), 64'(1));
    check_s("s_after_reset", 1'b0, '0);
    @(negedge clk);

    // Op sweep, a=CA b=0F, streaming one op per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(8'hCA, 8'h0F, 3'(i), 1'b0);
      if (i > 0) expect_head($sformatf("sweep%0d", i - 1), sweep[i-1]);
      tick();
    end
    in_valid = 1'b0;
    expect_head("sweep7", sweep[7]);
    tick();
    tick();

    // Accumulate chain after reset.
    do_reset();
    tick();
    drive(8'hFF, 8'h55, 3'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    expect_head("acc_and", 8'h00);
    drive(8'h3C, 8'h00, 3'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    expect_head("acc_or", 8'h3C);
    drive(8'hFF, 8'h00, 3'd2, 1'b1);
    tick();
    in_valid = 1'b0;
    expect_head("acc_xor", 8'hC3);
    tick();

    // Backpressure: three back-to-back ops with the consumer stalled.
    out_ready = 1'b0;
    drive(8'h11, 8'h00, 3'd7, 1'b0); tick();
    drive(8'h22, 8'h00, 3'd7, 1'b0); tick();
    drive(8'h33, 8'h00, 3'd7, 1'b0);
    #1;
    check("bp_full_ready", 64'(in_ready), 64'(0));
    tick();
    tick();
    out_ready = 1'b1;
    expect_head("bp_first", 8'h11);
    tick();                       // head removed; third op still blocked this cycle
    expect_head("bp_second", 8'h22);
    tick();                       // third op accepted now
    in_valid = 1'b0;
    expect_head("bp_third", 8'h33);
    tick();
    tick();

    // Full-rate streaming at occupancy 1 for 20 cycles; pointers wrap repeatedly.
    drive(8'h01, 8'h00, 3'd7, 1'b0);
    out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(8'(8'h40 + i), 8'h00, 3'd7, 1'b0);
      expect_head($sformatf("stream%0d", i), (i == 0) ? 8'h01 : 8'(8'h40 + i - 1));
      check("stream_ready", 64'(in_ready), 64'(1));
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Tri-state: buffered result hidden by EN=0, visible with EN=1, Z when empty.
    out_ready = 1'b0;
    EN = 1'b0;
    drive(8'h9E, 8'h00, 3'd7, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    check("tri_valid", 64'(out_valid), 64'(1));
    check_s("tri_off", 1'b0, '0);
    tick();
    EN = 1'b1;
    expect_head("tri_on", 8'h9E);
    out_ready = 1'b1;
    tick();
    #1;
    check_s("tri_empty", 1'b0, '0);
    tick();

    // Reset mid-operation with a full buffer and accumulator 0x5A.
    out_ready = 1'b0;
    drive(8'h11, 8'h00, 3'd7, 1'b0); tick();
    drive(8'h5A, 8'h00, 3'd7, 1'b0); tick();
    drive(8'hEE, 8'h00, 3'd7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check_s("midrst_s", 1'b0, '0);
    tick();
    out_ready = 1'b1;
    drive(8'h0F, 8'hF0, 3'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    expect_head("midrst_acc", 8'h0F);
    tick();

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      a         = 8'($urandom);
      b         = 8'($urandom);
      op        = 3'($urandom);
      acc       = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      EN        = ($urandom_range(0, 4) != 0);
      rst       = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
